// File: rtl/prtc_pram_seq.sv
// prtc_pram_seq -- PRTC parameter-RAM dump/restore sequencer.
//
// Walks PRAM addresses 0..LAST_ADDR and drives the PRTC port (C033/C034)
// through a six-operation slot per byte, stealing the port from the CPU only
// while a slot is in progress. Outside a slot the CPU passes straight through.
//
// Build option: define PRTC_SEQ_VERIFY_EN to add a read-back VERIFY pass after
// every restore that flags any byte differing from host_rdata on host_err.
//
// Ports
//   CLK_14M, reset_n        clock, asynchronous active-low reset
//   cen                     bus clock enable (one port operation per cen)
//   cpu_strobe/addr/rw/din  CPU side of the PRTC port (addr 0=C033, 1=C034)
//   cpu_dout, cpu_stall     CPU read data, engine owns the port
//   prtc_strobe/addr/rw/din muxed access to the PRTC
//   prtc_dout               PRTC read data
//   host_dump/host_restore  start pulses
//   host_addr               current PRAM address
//   host_rdata              restore data for host_addr (combinational)
//   host_wdata/host_wr      dumped byte and its one-cycle valid strobe
//   host_busy/done/err      status (done pulses, err sticky until next start)
module prtc_pram_seq #(
    parameter logic [7:0] LAST_ADDR = 8'hFF
) (
    input  logic       CLK_14M,
    input  logic       reset_n,
    input  logic       cen,
    input  logic       cpu_strobe,
    input  logic       cpu_addr,
    input  logic       cpu_rw,
    input  logic [7:0] cpu_din,
    output logic [7:0] cpu_dout,
    output logic       cpu_stall,
    output logic       prtc_strobe,
    output logic       prtc_addr,
    output logic       prtc_rw,
    output logic [7:0] prtc_din,
    input  logic [7:0] prtc_dout,
    input  logic       host_dump,
    input  logic       host_restore,
    output logic [7:0] host_addr,
    input  logic [7:0] host_rdata,
    output logic [7:0] host_wdata,
    output logic       host_wr,
    output logic       host_busy,
    output logic       host_done,
    output logic       host_err
);

`ifdef PRTC_SEQ_VERIFY_EN
    typedef enum logic [2:0] {StIdle, StArm, StSlot, StNext, StFin, StVerify} state_e;
`else
    typedef enum logic [2:0] {StIdle, StArm, StSlot, StNext, StFin} state_e;
`endif

    state_e     state_q, state_d;
    logic [7:0] addr_q, addr_d;
    logic [2:0] op_q, op_d;
    logic       restore_q, restore_d;
    logic [7:0] wdata_q, wdata_d;
    logic       wr_q, wr_d;
    logic       in_slot;
    logic       start_ok;
    logic       dump_style;

`ifdef PRTC_SEQ_VERIFY_EN
    logic verify_q, verify_d;
    logic err_q, err_d;
    // The verify pass reuses the dump-style read slots.
    assign dump_style = !restore_q || verify_q;
    assign host_err   = err_q;
`else
    assign dump_style = !restore_q;
    assign host_err   = 1'b0;
`endif

    always_ff @(posedge CLK_14M or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            addr_q    <= 8'h00;
            op_q      <= 3'd0;
            restore_q <= 1'b0;
            wdata_q   <= 8'h00;
            wr_q      <= 1'b0;
`ifdef PRTC_SEQ_VERIFY_EN
            verify_q  <= 1'b0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            op_q      <= op_d;
            restore_q <= restore_d;
            wdata_q   <= wdata_d;
            wr_q      <= wr_d;
`ifdef PRTC_SEQ_VERIFY_EN
            verify_q  <= verify_d;
            err_q     <= err_d;
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        op_d      = op_q;
        restore_d = restore_q;
        wdata_d   = wdata_q;
        wr_d      = 1'b0;
        in_slot   = 1'b0;
        start_ok  = 1'b0;
`ifdef PRTC_SEQ_VERIFY_EN
        verify_d  = verify_q;
        err_d     = err_q;
`endif
        case (state_q)
            StIdle: start_ok = 1'b1;
            StArm: begin
                // Op 0 goes out in the same cycle the CPU leaves the port free.
                if (cen && !cpu_strobe) begin
                    in_slot = 1'b1;
                    op_d    = 3'd1;
                    state_d = StSlot;
                end
            end
            StSlot: begin
                in_slot = 1'b1;
                if (cen) begin
                    if (op_q == 3'd5) begin
                        op_d    = 3'd0;
                        state_d = StNext;
                    end else begin
                        op_d = op_q + 3'd1;
                    end
                end
            end
            StNext: begin
                // Waiting for cen guarantees the CPU one free bus cycle.
                if (cen) begin
                    if (addr_q == LAST_ADDR) begin
`ifdef PRTC_SEQ_VERIFY_EN
                        state_d = (restore_q && !verify_q) ? StVerify : StFin;
`else
                        state_d = StFin;
`endif
                    end else begin
                        addr_d  = addr_q + 8'd1;
                        state_d = StArm;
                    end
                end
            end
            StFin: begin
                // busy is already low here, so a start is honoured.
                state_d  = StIdle;
                start_ok = 1'b1;
            end
`ifdef PRTC_SEQ_VERIFY_EN
            StVerify: begin
                addr_d   = 8'h00;
                verify_d = 1'b1;
                state_d  = StArm;
            end
`endif
            default: state_d = StIdle;
        endcase

        if (start_ok && (host_dump || host_restore)) begin
            state_d   = StArm;
            addr_d    = 8'h00;
            op_d      = 3'd0;
            restore_d = !host_dump;
`ifdef PRTC_SEQ_VERIFY_EN
            verify_d  = 1'b0;
            err_d     = 1'b0;
`endif
        end

        // Op 5 of a dump-style slot is the data read.
        if (in_slot && cen && op_q == 3'd5 && dump_style) begin
`ifdef PRTC_SEQ_VERIFY_EN
            if (verify_q) begin
                if (prtc_dout != host_rdata) err_d = 1'b1;
            end else begin
                wdata_d = prtc_dout;
                wr_d    = 1'b1;
            end
`else
            wdata_d = prtc_dout;
            wr_d    = 1'b1;
`endif
        end
    end

    // Port mux: pass-through unless a slot owns the port.
    always_comb begin
        prtc_strobe = cpu_strobe;
        prtc_addr   = cpu_addr;
        prtc_rw     = cpu_rw;
        prtc_din    = cpu_din;
        cpu_dout    = prtc_dout;
        cpu_stall   = 1'b0;
        if (in_slot) begin
            cpu_stall   = 1'b1;
            cpu_dout    = 8'h00;
            prtc_strobe = cen;
            prtc_addr   = 1'b0;
            prtc_rw     = 1'b0;
            prtc_din    = 8'h80;
            case (op_q)
                3'd0: prtc_din = {5'b00111, addr_q[7:5]};
                3'd1: prtc_addr = 1'b1;
                3'd2: prtc_din = {1'b0, addr_q[4:0], 2'b00};
                3'd3: prtc_addr = 1'b1;
                3'd4: begin
                    if (dump_style) begin
                        prtc_addr = 1'b1;
                        prtc_din  = 8'hC0;
                    end else begin
                        prtc_din = host_rdata;
                    end
                end
                default: begin
                    if (dump_style) begin
                        prtc_rw  = 1'b1;
                        prtc_din = 8'h00;
                    end else begin
                        prtc_addr = 1'b1;
                    end
                end
            endcase
        end
    end

    assign host_addr  = addr_q;
    assign host_wdata = wdata_q;
    assign host_wr    = wr_q;
    assign host_busy  = (state_q != StIdle) && (state_q != StFin);
    assign host_done  = (state_q == StFin);

endmodule

// File: tb/tb_prtc_pram_seq.sv
module tb_prtc_pram_seq;

    localparam int NBYTES = 256;
`ifdef PRTC_SEQ_VERIFY_EN
    localparam bit VERIFY_EN = 1'b1;
`else
    localparam bit VERIFY_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic       cen, cpu_strobe, cpu_addr, cpu_rw;
    logic [7:0] cpu_din, cpu_dout;
    logic       cpu_stall, prtc_strobe, prtc_addr, prtc_rw;
    logic [7:0] prtc_din, prtc_dout;
    logic       host_dump, host_restore;
    logic [7:0] host_addr, host_rdata, host_wdata;
    logic       host_wr, host_busy, host_done, host_err;

    always #5 clk = ~clk;

    prtc_pram_seq u_dut (
        .CLK_14M      (clk),
        .reset_n      (reset_n),
        .cen          (cen),
        .cpu_strobe   (cpu_strobe),
        .cpu_addr     (cpu_addr),
        .cpu_rw       (cpu_rw),
        .cpu_din      (cpu_din),
        .cpu_dout     (cpu_dout),
        .cpu_stall    (cpu_stall),
        .prtc_strobe  (prtc_strobe),
        .prtc_addr    (prtc_addr),
        .prtc_rw      (prtc_rw),
        .prtc_din     (prtc_din),
        .prtc_dout    (prtc_dout),
        .host_dump    (host_dump),
        .host_restore (host_restore),
        .host_addr    (host_addr),
        .host_rdata   (host_rdata),
        .host_wdata   (host_wdata),
        .host_wr      (host_wr),
        .host_busy    (host_busy),
        .host_done    (host_done),
        .host_err     (host_err)
    );

    // PRTC model: PRAM array plus a command decoder (cmd, addr, then data
    // write or C0-read). Only engine-owned operations reach it.
    logic [7:0] pram      [NBYTES];
    logic [7:0] rdata_arr [NBYTES];
    logic [1:0] m_st;
    logic [2:0] m_hi;
    logic [4:0] m_lo;
    bit         corrupt_en;

    always_comb prtc_dout = (m_st == 2'd3) ? pram[{m_hi, m_lo}] : 8'hEE;
    assign host_rdata = rdata_arr[host_addr];

    int errors = 0;
    int checks = 0;

    int   cen_pct, cpu_pct, cpu_mode;
    bit   dump_req, restore_req;
    bit   pend_v, pend_addr, pend_rw;
    logic [7:0] pend_din;

    int   cyc, pt_bad, stall_bad, stall_cyc, done_cnt, done_cyc;
    logic done_err, done_busy;
    bit   timed_out;
    logic [9:0] ops[$];
    logic [7:0] wr_data[$];
    logic [7:0] wr_addr[$];

    task automatic clear_mon();
        cyc = 0; pt_bad = 0; stall_bad = 0; stall_cyc = 0; done_cnt = 0; done_cyc = -1;
        done_err = 1'b0; done_busy = 1'b0;
        ops.delete(); wr_data.delete(); wr_addr.delete();
    endtask

    // One clock: apply last cycle's engine op to the PRTC model, drive, sample.
    task automatic step();
        @(posedge clk);
        #1;
        if (pend_v) begin
            pend_v = 1'b0;
            if (!pend_rw && pend_addr && pend_din == 8'hC0 && m_st == 2'd2) begin
                m_st = 2'd3;
            end else if (!pend_rw && !pend_addr) begin
                case (m_st)
                    2'd0: begin m_hi = pend_din[2:0]; m_st = 2'd1; end
                    2'd1: begin m_lo = pend_din[6:2]; m_st = 2'd2; end
                    2'd2: begin
                        pram[{m_hi, m_lo}] = (corrupt_en && {m_hi, m_lo} == 8'h10) ?
                                             ~pend_din : pend_din;
                        m_st = 2'd0;
                    end
                    default: m_st = 2'd0;
                endcase
            end else if (pend_rw && !pend_addr) begin
                m_st = 2'd0;
            end
        end
        cen = ($urandom_range(99) < cen_pct);
        case (cpu_mode)
            0: cpu_strobe = ($urandom_range(99) < cpu_pct);
            1: cpu_strobe = 1'b1;
            default: cpu_strobe = 1'b0;
        endcase
        cpu_addr = $urandom; cpu_rw = $urandom; cpu_din = $urandom;
        host_dump = dump_req; host_restore = restore_req;
        dump_req = 1'b0; restore_req = 1'b0;
        @(negedge clk);
        cyc++;
        if (cpu_stall) begin
            stall_cyc++;
            if (cpu_dout !== 8'h00 || prtc_strobe !== cen) stall_bad++;
            if (prtc_strobe) begin
                pend_v = 1'b1; pend_addr = prtc_addr; pend_rw = prtc_rw; pend_din = prtc_din;
                ops.push_back({prtc_addr, prtc_rw, prtc_din});
            end
        end else if (prtc_strobe !== cpu_strobe || prtc_addr !== cpu_addr ||
                     prtc_rw !== cpu_rw || prtc_din !== cpu_din || cpu_dout !== prtc_dout) begin
            pt_bad++;
        end
        if (host_wr) begin
            wr_data.push_back(host_wdata);
            wr_addr.push_back(host_addr);
        end
        if (host_done) begin
            done_cnt++;
            if (done_cyc < 0) begin
                done_cyc = cyc; done_err = host_err; done_busy = host_busy;
            end
        end
    endtask

    task automatic run_to_done(input int budget);
        int n = 0;
        timed_out = 1'b0;
        while (done_cnt == 0 && n < budget) begin
            step();
            n++;
        end
        if (done_cnt == 0) timed_out = 1'b1;
    endtask

    function automatic int dump_mismatches();
        int bad = 0;
        for (int i = 0; i < wr_data.size(); i++)
            if (wr_data[i] !== pram[i] || wr_addr[i] !== 8'(i)) bad++;
        return bad;
    endfunction

    task automatic test_reset();
        reset_n = 1'b0;
        cpu_strobe = 1'b1; cpu_addr = 1'b1; cpu_rw = 1'b0; cpu_din = 8'hA7;
        repeat (3) @(negedge clk);
        checks++;
        if ({host_busy, host_done, host_wr, host_err, cpu_stall} !== 5'b0) begin
            errors++; $display("FAIL reset_flags: got %b, expected 00000",
                               {host_busy, host_done, host_wr, host_err, cpu_stall});
        end
        checks++;
        if (host_addr !== 8'h00) begin
            errors++; $display("FAIL reset_addr: got %0h, expected 0", host_addr);
        end
        checks++;
        if (host_wdata !== 8'h00) begin
            errors++; $display("FAIL reset_wdata: got %0h, expected 0", host_wdata);
        end
        checks++;
        if ({prtc_strobe, prtc_addr, prtc_rw, prtc_din} !== {1'b1, 1'b1, 1'b0, 8'hA7}) begin
            errors++; $display("FAIL reset_passthru: got %0h, expected %0h",
                               {prtc_strobe, prtc_addr, prtc_rw, prtc_din}, 11'h6A7);
        end
        checks++;
        if (cpu_dout !== 8'hEE) begin
            errors++; $display("FAIL reset_cpu_dout: got %0h, expected ee", cpu_dout);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_passthrough();
        clear_mon();
        cen_pct = 50; cpu_pct = 60; cpu_mode = 0;
        repeat (60) step();
        checks++;
        if (pt_bad !== 0) begin
            errors++; $display("FAIL idle_passthru: got %0d bad cycles, expected 0", pt_bad);
        end
        checks++;
        if (stall_cyc !== 0) begin
            errors++; $display("FAIL idle_stall: got %0d stall cycles, expected 0", stall_cyc);
        end
    endtask

    task automatic test_dump();
        for (int i = 0; i < NBYTES; i++) pram[i] = 8'($urandom);
        clear_mon();
        cen_pct = 100; cpu_pct = 0; cpu_mode = 0;
        dump_req = 1'b1;
        step();
        checks++;
        if (host_busy !== 1'b0) begin
            errors++; $display("FAIL dump_busy_pre: got %b, expected 0", host_busy);
        end
        step();
        checks++;
        if (host_busy !== 1'b1) begin
            errors++; $display("FAIL dump_busy: got %b, expected 1", host_busy);
        end
        run_to_done(3000);
        checks++;
        if (timed_out) begin
            errors++; $display("FAIL dump_timeout: got no done, expected done");
        end
        // Cycles from the start-sampling edge to done, less that edge: 7 per byte.
        checks++;
        if (done_cyc - 2 !== 7 * NBYTES) begin
            errors++; $display("FAIL dump_latency: got %0d, expected %0d", done_cyc - 2,
                               7 * NBYTES);
        end
        checks++;
        if (ops.size() > 0 && ops[0] !== 10'h038) begin
            errors++; $display("FAIL dump_first_op: got %0h, expected 038", ops[0]);
        end
        checks++;
        if (wr_data.size() !== NBYTES) begin
            errors++; $display("FAIL dump_wr_count: got %0d, expected %0d", wr_data.size(),
                               NBYTES);
        end
        checks++;
        if (dump_mismatches() !== 0) begin
            errors++; $display("FAIL dump_data: got %0d bad bytes, expected 0",
                               dump_mismatches());
        end
        checks++;
        if (done_busy !== 1'b0 || done_err !== 1'b0) begin
            errors++; $display("FAIL dump_done_status: got busy=%b err=%b, expected 0 0",
                               done_busy, done_err);
        end
        repeat (3) step();
        checks++;
        if (done_cnt !== 1 || pt_bad !== 0 || stall_bad !== 0) begin
            errors++; $display("FAIL dump_port: got done=%0d pt=%0d st=%0d, expected 1 0 0",
                               done_cnt, pt_bad, stall_bad);
        end
    endtask

    task automatic test_contention();
        clear_mon();
        cen_pct = 100; cpu_mode = 1;
        dump_req = 1'b1;
        step();
        repeat (10) step();
        checks++;
        if (ops.size() !== 0 || stall_cyc !== 0) begin
            errors++; $display("FAIL arm_wait: got ops=%0d stalls=%0d, expected 0 0",
                               ops.size(), stall_cyc);
        end
        cpu_mode = 2;
        step();
        checks++;
        if (ops.size() !== 1 || stall_cyc !== 1) begin
            errors++; $display("FAIL arm_release: got ops=%0d stalls=%0d, expected 1 1",
                               ops.size(), stall_cyc);
        end else if (ops[0] !== 10'h038) begin
            errors++; $display("FAIL arm_op0: got %0h, expected 038", ops[0]);
        end
        cpu_mode = 0; cpu_pct = 40; cen_pct = 80;
        run_to_done(8000);
        checks++;
        if (timed_out || wr_data.size() !== NBYTES || dump_mismatches() !== 0) begin
            errors++; $display("FAIL contention_dump: got to=%b wr=%0d bad=%0d, expected 0 %0d 0",
                               timed_out, wr_data.size(), dump_mismatches(), NBYTES);
        end
        checks++;
        if (pt_bad !== 0 || stall_bad !== 0) begin
            errors++; $display("FAIL contention_port: got pt=%0d st=%0d, expected 0 0",
                               pt_bad, stall_bad);
        end
    endtask

    task automatic test_restore();
        int bad = 0;
        logic [9:0] exp_a5 [6];
        exp_a5 = '{10'h03D, 10'h280, 10'h014, 10'h280, 10'h05A, 10'h280};
        for (int i = 0; i < NBYTES; i++) begin
            rdata_arr[i] = 8'($urandom);
            pram[i] = ~rdata_arr[i];
        end
        rdata_arr[8'hA5] = 8'h5A;
        pram[8'hA5] = 8'h00;
        corrupt_en = 1'b0;
        clear_mon();
        cen_pct = 70; cpu_pct = 30; cpu_mode = 0;
        restore_req = 1'b1;
        step();
        run_to_done(20000);
        checks++;
        if (timed_out) begin
            errors++; $display("FAIL restore_timeout: got no done, expected done");
        end
        for (int i = 0; i < NBYTES; i++) if (pram[i] !== rdata_arr[i]) bad++;
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL restore_data: got %0d bad bytes, expected 0", bad);
        end
        checks++;
        if (ops.size() !== (VERIFY_EN ? 12 : 6) * NBYTES) begin
            errors++; $display("FAIL restore_op_count: got %0d, expected %0d", ops.size(),
                               (VERIFY_EN ? 12 : 6) * NBYTES);
        end
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (ops.size() > 6 * 8'hA5 + k && ops[6 * 8'hA5 + k] !== exp_a5[k]) begin
                errors++; $display("FAIL restore_a5_op%0d: got %0h, expected %0h", k,
                                   ops[6 * 8'hA5 + k], exp_a5[k]);
            end
        end
        checks++;
        if (wr_data.size() !== 0 || done_err !== 1'b0) begin
            errors++; $display("FAIL restore_status: got wr=%0d err=%b, expected 0 0",
                               wr_data.size(), done_err);
        end
        checks++;
        if (pt_bad !== 0 || stall_bad !== 0) begin
            errors++; $display("FAIL restore_port: got pt=%0d st=%0d, expected 0 0",
                               pt_bad, stall_bad);
        end
    endtask

    task automatic test_both_start();
        for (int i = 0; i < NBYTES; i++) pram[i] = 8'($urandom);
        clear_mon();
        cen_pct = 100; cpu_pct = 0; cpu_mode = 0;
        dump_req = 1'b1; restore_req = 1'b1;
        step();
        repeat (50) step();
        restore_req = 1'b1;
        run_to_done(3000);
        repeat (20) step();
        checks++;
        if (done_cnt !== 1 || timed_out) begin
            errors++; $display("FAIL both_done: got %0d, expected 1", done_cnt);
        end
        checks++;
        if (wr_data.size() !== NBYTES || dump_mismatches() !== 0) begin
            errors++; $display("FAIL both_dump: got wr=%0d bad=%0d, expected %0d 0",
                               wr_data.size(), dump_mismatches(), NBYTES);
        end
        checks++;
        if (ops.size() !== 6 * NBYTES) begin
            errors++; $display("FAIL both_ignored: got %0d ops, expected %0d", ops.size(),
                               6 * NBYTES);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        clear_mon();
        cen_pct = 100; cpu_pct = 0; cpu_mode = 0;
        dump_req = 1'b1;
        step();
        while (ops.size() < 4 && n < 40) begin
            step();
            n++;
        end
        checks++;
        if (ops.size() !== 4) begin
            errors++; $display("FAIL rst_mid_reach_op3: got %0d ops, expected 4", ops.size());
        end
        // Now mid op 3 (just before its edge).
        reset_n = 1'b0;
        cpu_strobe = 1'b1; cpu_addr = 1'b0; cpu_rw = 1'b0; cpu_din = 8'h5C;
        #1;
        checks++;
        if ({host_busy, host_done, host_wr, host_err, cpu_stall} !== 5'b0 ||
            host_addr !== 8'h00 || host_wdata !== 8'h00) begin
            errors++; $display("FAIL rst_mid_outputs: got %b %0h %0h, expected 00000 0 0",
                               {host_busy, host_done, host_wr, host_err, cpu_stall},
                               host_addr, host_wdata);
        end
        checks++;
        if ({prtc_strobe, prtc_addr, prtc_rw, prtc_din} !== {3'b100, 8'h5C}) begin
            errors++; $display("FAIL rst_mid_passthru: got %0h, expected 45c",
                               {prtc_strobe, prtc_addr, prtc_rw, prtc_din});
        end
        pend_v = 1'b0; m_st = 2'd0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < NBYTES; i++) pram[i] = 8'($urandom);
        clear_mon();
        dump_req = 1'b1;
        step();
        run_to_done(3000);
        checks++;
        if (ops.size() < 3 || ops[0] !== 10'h038 || ops[2] !== 10'h000) begin
            errors++; $display("FAIL rst_restart_addr0: got %0d ops, expected op0=038 op2=000",
                               ops.size());
        end
        checks++;
        if (timed_out || wr_data.size() !== NBYTES || dump_mismatches() !== 0) begin
            errors++; $display("FAIL rst_restart_dump: got wr=%0d bad=%0d, expected %0d 0",
                               wr_data.size(), dump_mismatches(), NBYTES);
        end
    endtask

    task automatic test_corrupt();
        for (int i = 0; i < NBYTES; i++) rdata_arr[i] = 8'($urandom);
        corrupt_en = 1'b1;
        clear_mon();
        cen_pct = 100; cpu_pct = 0; cpu_mode = 0;
        restore_req = 1'b1;
        step();
        run_to_done(8000);
        corrupt_en = 1'b0;
        checks++;
        if (timed_out || done_err !== VERIFY_EN) begin
            errors++; $display("FAIL corrupt_err_at_done: got %b, expected %b", done_err,
                               VERIFY_EN);
        end
        repeat (5) step();
        checks++;
        if (host_err !== VERIFY_EN) begin
            errors++; $display("FAIL corrupt_err_sticky: got %b, expected %b", host_err,
                               VERIFY_EN);
        end
        dump_req = 1'b1;
        step();
        step();
        checks++;
        if (host_err !== 1'b0) begin
            errors++; $display("FAIL corrupt_err_clear: got %b, expected 0", host_err);
        end
        clear_mon();
        run_to_done(3000);
    endtask

    initial begin
        reset_n = 1'b0; cen = 1'b0; cpu_strobe = 1'b0; cpu_addr = 1'b0; cpu_rw = 1'b0;
        cpu_din = 8'h00; host_dump = 1'b0; host_restore = 1'b0;
        dump_req = 1'b0; restore_req = 1'b0; pend_v = 1'b0; corrupt_en = 1'b0;
        m_st = 2'd0; m_hi = 3'd0; m_lo = 5'd0;
        cen_pct = 100; cpu_pct = 0; cpu_mode = 0;
        for (int i = 0; i < NBYTES; i++) begin
            pram[i] = 8'h00;
            rdata_arr[i] = 8'h00;
        end
        clear_mon();
        test_reset();
        test_passthrough();
        test_dump();
        test_contention();
        test_restore();
        test_both_start();
        test_reset_mid();
        test_corrupt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
